mem_arbiter: RTL and testbench

- Sequences the single shared RAM port between the instruction and data caches of both cores.
- Requesters: core0 icache, core0 dcache, core1 icache, core1 dcache.
- One access is granted at a time and held until RAM completes. Cores rotate round-robin; data-before-instruction priority applies within a core.
- Sits between the per-core icache/dcache memory-side ports and RAM.

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter_rr_select.sv | 32 +++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-side arbiter: RAM handshake states, arbiter FSM
// states and the latched grant identity.
package cpu_types_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic core;
        logic is_data;
    } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the per-core cache memory ports and the single RAM port.
// master = caches plus RAM (the surroundings), slave = the arbiter itself.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      [1:0] iREN;
    addr_t     [1:0] iaddr;
    logic      [1:0] iwait;
    word_t     [1:0] iload;

    logic      [1:0] dREN;
    logic      [1:0] dWEN;
    addr_t     [1:0] daddr;
    word_t     [1:0] dstore;
    logic      [1:0] dwait;
    word_t     [1:0] dload;

    logic            ramREN;
    logic            ramWEN;
    addr_t           ramaddr;
    word_t           ramstore;
    word_t           ramload;
    ramstate_t       ramstate;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter_rr_select.sv
// Combinational winner picker: round-robin between cores, fixed
// data/instruction priority inside the chosen core.
module rr_select
    import cpu_types_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic [1:0] ireq,
    input  logic [1:0] dreq,
    input  logic       rr_core,
    output logic       valid,
    output grant_t     grant
);

    logic [1:0] core_req;
    logic       sel_core;

    assign core_req = ireq | dreq;

    // The favoured core keeps its turn only if it actually has something pending.
    always_comb begin
        sel_core = core_req[rr_core] ? rr_core : ~rr_core;
        valid    = |core_req;
        grant.core = sel_core;
        if (DATA_FIRST) begin
            grant.is_data = dreq[sel_core];
        end else begin
            grant.is_data = ~ireq[sel_core];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the icache and dcache of two cores; one access
// at a time, held until RAM reports ACCESS or the requester withdraws.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input logic          CLK,
    input logic          RST,
    mem_arbiter_if.slave bus
);

    arb_state_t state;
    arb_state_t next_state;
    grant_t     grant;
    grant_t     sel_grant;
    logic       sel_valid;
    logic       rr_core;
    logic [1:0] dreq;
    logic       granted_active;
    logic       complete;

    logic       ram_ren;
    logic       ram_wen;
    addr_t      ram_addr;
    word_t      ram_store;
    logic [1:0] i_wait;
    logic [1:0] d_wait;
    word_t [1:0] i_load;
    word_t [1:0] d_load;

    // A dcache request is either a read or a write; both together count as a write.
    assign dreq = bus.dREN | bus.dWEN;

    rr_select #(
        .DATA_FIRST(DATA_FIRST)
    ) u_rr_select (
        .ireq    (bus.iREN),
        .dreq    (dreq),
        .rr_core (rr_core),
        .valid   (sel_valid),
        .grant   (sel_grant)
    );

    assign granted_active = grant.is_data ? dreq[grant.core] : bus.iREN[grant.core];
    assign complete       = (state == GRANT) && granted_active && (bus.ramstate == ACCESS);

    // Only the grant identity is registered; the turn passes to the other core
    // solely on a real completion, so an aborted access keeps the same turn.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            grant   <= '0;
            rr_core <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && sel_valid) begin
                grant <= sel_grant;
            end
            if (complete) begin
                rr_core <= ~grant.core;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    next_state = GRANT;
                end
            end
            GRANT: begin
                if (!granted_active || complete) begin
                    next_state = IDLE;
                end
            end
        endcase
    end

    // Address and data are passed straight through from the granted requester.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        i_wait    = 2'b11;
        d_wait    = 2'b11;
        i_load    = '0;
        d_load    = '0;
        if ((state == GRANT) && granted_active) begin
            if (grant.is_data) begin
                ram_wen   = bus.dWEN[grant.core];
                ram_ren   = ~bus.dWEN[grant.core];
                ram_addr  = bus.daddr[grant.core];
                ram_store = bus.dstore[grant.core];
            end else begin
                ram_ren  = 1'b1;
                ram_addr = bus.iaddr[grant.core];
            end
            if (bus.ramstate == ACCESS) begin
                if (grant.is_data) begin
                    d_wait[grant.core] = 1'b0;
                    if (!bus.dWEN[grant.core]) begin
                        d_load[grant.core] = bus.ramload;
                    end
                end else begin
                    i_wait[grant.core] = 1'b0;
                    i_load[grant.core] = bus.ramload;
                end
            end
        end
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.iwait    = i_wait;
    assign bus.dwait    = d_wait;
    assign bus.iload    = i_load;
    assign bus.dload    = d_load;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic against a requester-level reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam bit DATA_FIRST = 1'b1;

    typedef struct {
        logic        ren;
        logic        wen;
        addr_t       addr;
        word_t       store;
        logic [1:0]  iwait;
        logic [1:0]  dwait;
        word_t [1:0] iload;
        word_t [1:0] dload;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [1:0] iren;
        logic [1:0] dren;
        logic [1:0] dwen;
        ramstate_t  rs;
        word_t      ramload;
        exp_t       e;
    } vec_t;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    // Reference model: owner = -1 when nobody holds the RAM, else core*2 + is_data.
    int owner;
    int rr;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .DATA_FIRST(DATA_FIRST)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mkExp(input logic ren, input logic wen, input addr_t addr,
                                   input word_t store, input logic [1:0] iwait,
                                   input logic [1:0] dwait, input word_t [1:0] iload,
                                   input word_t [1:0] dload);
        exp_t e;
        e.ren = ren; e.wen = wen; e.addr = addr; e.store = store;
        e.iwait = iwait; e.dwait = dwait; e.iload = iload; e.dload = dload;
        return e;
    endfunction

    function automatic vec_t mkVec(input logic rst, input logic [1:0] iren, input logic [1:0] dren,
                                   input logic [1:0] dwen, input ramstate_t rs,
                                   input word_t ramload, input exp_t e);
        vec_t v;
        v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen;
        v.rs = rs; v.ramload = ramload; v.e = e;
        return v;
    endfunction

    function automatic bit reqOf(input int idx);
        int c;
        c = idx / 2;
        if (idx % 2 == 1) return bus.dREN[c] | bus.dWEN[c];
        return bus.iREN[c];
    endfunction

    function automatic exp_t computeExpected();
        exp_t e;
        int   c;
        e = mkExp(1'b0, 1'b0, '0, '0, 2'b11, 2'b11, '0, '0);
        if (owner >= 0 && reqOf(owner)) begin
            c = owner / 2;
            if (owner % 2 == 1) begin
                e.wen   = bus.dWEN[c];
                e.ren   = !bus.dWEN[c];
                e.addr  = bus.daddr[c];
                e.store = bus.dstore[c];
                if (bus.ramstate == ACCESS) begin
                    e.dwait[c] = 1'b0;
                    if (!bus.dWEN[c]) e.dload[c] = bus.ramload;
                end
            end else begin
                e.ren  = 1'b1;
                e.addr = bus.iaddr[c];
                if (bus.ramstate == ACCESS) begin
                    e.iwait[c] = 1'b0;
                    e.iload[c] = bus.ramload;
                end
            end
        end
        return e;
    endfunction

    task automatic modelUpdate();
        int c;
        int pref;
        if (RST) begin
            owner = -1;
            rr    = 0;
        end else if (owner < 0) begin
            pref = DATA_FIRST ? 1 : 0;
            for (int k = 0; k < 2; k++) begin
                c = (k == 0) ? rr : 1 - rr;
                if (owner < 0 && reqOf(c * 2 + pref)) owner = c * 2 + pref;
                else if (owner < 0 && reqOf(c * 2 + 1 - pref)) owner = c * 2 + 1 - pref;
            end
        end else if (!reqOf(owner)) begin
            owner = -1;
        end else if (bus.ramstate == ACCESS) begin
            rr    = 1 - owner / 2;
            owner = -1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        RST          = v.rst;
        bus.iREN     = v.iren;
        bus.dREN     = v.dren;
        bus.dWEN     = v.dwen;
        bus.ramstate = v.rs;
        bus.ramload  = v.ramload;
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        check({tag, ".ramREN"},   64'(bus.ramREN),   64'(e.ren));
        check({tag, ".ramWEN"},   64'(bus.ramWEN),   64'(e.wen));
        check({tag, ".ramaddr"},  64'(bus.ramaddr),  64'(e.addr));
        check({tag, ".ramstore"}, 64'(bus.ramstore), 64'(e.store));
        check({tag, ".iwait"},    64'(bus.iwait),    64'(e.iwait));
        check({tag, ".dwait"},    64'(bus.dwait),    64'(e.dwait));
        check({tag, ".iload"},    64'(bus.iload),    64'(e.iload));
        check({tag, ".dload"},    64'(bus.dload),    64'(e.dload));
    endtask

    task automatic finishCycle();
        @(posedge CLK);
        modelUpdate();
        #1;
    endtask

    task automatic modelCycle(input string tag);
        @(negedge CLK);
        checkOutput(computeExpected(), tag);
        finishCycle();
    endtask

    vec_t      tbl[$];
    exp_t      idle_e;
    ramstate_t stall_rs[7];
    int        pulses;
    int        prev_core;
    int        cur_core;
    int        r;

    initial begin
        checks = 0;
        errors = 0;
        owner  = -1;
        rr     = 0;
        RST    = 1'b1;
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr  = {32'h0000_0080, 32'h0000_0040};
        bus.daddr  = {32'h0000_0100, 32'h0000_0200};
        bus.dstore = {32'h1234_5678, 32'hCAFE_F00D};
        bus.ramload  = '0;
        bus.ramstate = FREE;
        repeat (2) finishCycle();
        RST = 1'b0;

        idle_e = mkExp(1'b0, 1'b0, '0, '0, 2'b11, 2'b11, '0, '0);
        // single instruction read with one BUSY cycle
        tbl.push_back(mkVec(0, 2'b01, 2'b00, 2'b00, FREE,   '0, idle_e));
        tbl.push_back(mkVec(0, 2'b01, 2'b00, 2'b00, BUSY,   '0,
                            mkExp(1, 0, 32'h40, '0, 2'b11, 2'b11, '0, '0)));
        tbl.push_back(mkVec(0, 2'b01, 2'b00, 2'b00, ACCESS, 32'hDEAD_BEEF,
                            mkExp(1, 0, 32'h40, '0, 2'b10, 2'b11, {32'h0, 32'hDEAD_BEEF}, '0)));
        tbl.push_back(mkVec(0, 2'b00, 2'b00, 2'b00, FREE,   '0, idle_e));
        // core1 dcache write beats core1 icache, then icache is served
        tbl.push_back(mkVec(0, 2'b10, 2'b00, 2'b10, FREE,   '0, idle_e));
        tbl.push_back(mkVec(0, 2'b10, 2'b00, 2'b10, ACCESS, 32'hDEAD_BEEF,
                            mkExp(0, 1, 32'h100, 32'h1234_5678, 2'b11, 2'b01, '0, '0)));
        tbl.push_back(mkVec(0, 2'b10, 2'b00, 2'b00, FREE,   '0, idle_e));
        tbl.push_back(mkVec(0, 2'b10, 2'b00, 2'b00, ACCESS, 32'h0BAD_F00D,
                            mkExp(1, 0, 32'h80, '0, 2'b01, 2'b11, {32'h0BAD_F00D, 32'h0}, '0)));
        tbl.push_back(mkVec(0, 2'b00, 2'b00, 2'b00, FREE,   '0, idle_e));
        // abort: core0 icache drops its request before completion
        tbl.push_back(mkVec(0, 2'b01, 2'b00, 2'b00, FREE,   '0, idle_e));
        tbl.push_back(mkVec(0, 2'b01, 2'b00, 2'b00, BUSY,   '0,
                            mkExp(1, 0, 32'h40, '0, 2'b11, 2'b11, '0, '0)));
        tbl.push_back(mkVec(0, 2'b00, 2'b00, 2'b00, ACCESS, 32'hDEAD_BEEF, idle_e));
        // turn still belongs to core0 after the abort
        tbl.push_back(mkVec(0, 2'b11, 2'b00, 2'b00, FREE,   '0, idle_e));
        tbl.push_back(mkVec(0, 2'b11, 2'b00, 2'b00, ACCESS, 32'h1111_2222,
                            mkExp(1, 0, 32'h40, '0, 2'b10, 2'b11, {32'h0, 32'h1111_2222}, '0)));
        tbl.push_back(mkVec(0, 2'b11, 2'b00, 2'b00, FREE,   '0, idle_e));
        tbl.push_back(mkVec(0, 2'b11, 2'b00, 2'b00, ACCESS, 32'h3333_4444,
                            mkExp(1, 0, 32'h80, '0, 2'b01, 2'b11, {32'h3333_4444, 32'h0}, '0)));
        tbl.push_back(mkVec(0, 2'b00, 2'b00, 2'b00, FREE,   '0, idle_e));
        // dREN and dWEN together behave as a write
        tbl.push_back(mkVec(0, 2'b00, 2'b01, 2'b01, FREE,   '0, idle_e));
        tbl.push_back(mkVec(0, 2'b00, 2'b01, 2'b01, ACCESS, 32'h5555_6666,
                            mkExp(0, 1, 32'h200, 32'hCAFE_F00D, 2'b11, 2'b10, '0, '0)));
        // ACCESS while idle is ignored
        tbl.push_back(mkVec(0, 2'b00, 2'b00, 2'b00, ACCESS, 32'h7777_8888, idle_e));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            @(negedge CLK);
            checkOutput(tbl[i].e, $sformatf("vec%0d", i));
            finishCycle();
        end

        // reset in the middle of a core1 write; afterwards core0 must win again
        bus.dWEN = 2'b10; bus.ramstate = FREE;
        modelCycle("rst_c0");
        bus.ramstate = BUSY; RST = 1'b1;
        @(negedge CLK);
        checkOutput(computeExpected(), "rst_c1");
        check("rst_pre_wen", 64'(bus.ramWEN), 64'd1);
        finishCycle();
        RST = 1'b0; bus.dWEN = 2'b11; bus.ramstate = FREE;
        @(negedge CLK);
        checkOutput(computeExpected(), "rst_c2");
        check("rst_post_wen", 64'(bus.ramWEN), 64'd0);
        check("rst_post_dwait", 64'(bus.dwait), 64'b11);
        finishCycle();
        bus.ramstate = ACCESS;
        @(negedge CLK);
        checkOutput(computeExpected(), "rst_c3");
        check("rst_rr_core0", 64'(bus.dwait), 64'b10);
        finishCycle();
        bus.dWEN = 2'b00; bus.ramstate = FREE;
        modelCycle("rst_c4");

        // stall: BUSY x3, ERROR, ACCESS with stable RAM signals and one pulse
        stall_rs = '{FREE, BUSY, BUSY, BUSY, ERROR, ACCESS, FREE};
        pulses = 0;
        bus.dREN = 2'b10;
        foreach (stall_rs[i]) begin
            bus.ramstate = stall_rs[i];
            bus.ramload  = 32'h5A5A_5A5A;
            if (i == 6) bus.dREN = 2'b00;
            @(negedge CLK);
            checkOutput(computeExpected(), $sformatf("stall%0d", i));
            if (i >= 1 && i <= 5) begin
                check("stall_addr", 64'(bus.ramaddr), 64'h100);
                check("stall_ren", 64'(bus.ramREN), 64'd1);
            end
            if (bus.dwait != 2'b11 || bus.iwait != 2'b11) pulses++;
            finishCycle();
        end
        check("stall_pulses", 64'(pulses), 64'd1);

        // all four requesting with single-cycle RAM: dcache grants alternate cores
        bus.iREN = 2'b11; bus.dREN = 2'b11; bus.ramstate = ACCESS;
        pulses = 0; prev_core = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            checkOutput(computeExpected(), $sformatf("rr%0d", i));
            if (bus.dwait != 2'b11) begin
                pulses++;
                cur_core = bus.dwait[0] ? 1 : 0;
                if (prev_core >= 0) check("rr_alternate", 64'(cur_core), 64'(1 - prev_core));
                prev_core = cur_core;
            end
            finishCycle();
        end
        check("rr_pulses", 64'(pulses), 64'd6);
        bus.iREN = '0; bus.dREN = '0; bus.ramstate = FREE;
        modelCycle("rr_end");

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.iREN = 2'($urandom);
            if ($urandom_range(0, 3) == 0) bus.dREN = 2'($urandom);
            if ($urandom_range(0, 3) == 0) bus.dWEN = 2'($urandom);
            bus.iaddr   = {$urandom, $urandom};
            bus.daddr   = {$urandom, $urandom};
            bus.dstore  = {$urandom, $urandom};
            bus.ramload = $urandom;
            r = $urandom_range(0, 9);
            bus.ramstate = (r < 4) ? ACCESS : (r < 7) ? BUSY : (r < 8) ? ERROR : FREE;
            RST = ($urandom_range(0, 299) == 0);
            modelCycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
